// File: rtl/fsm_lockstep_pkg.sv
// Shared definitions for the lockstep FSM checker: state codes, control states, legality test.
package fsm_lockstep_pkg;

  localparam logic [2:0] Q0 = 3'd2;
  localparam logic [2:0] Q1 = 3'd6;
  localparam logic [2:0] Q2 = 3'd4;
  localparam logic [2:0] Q3 = 3'd7;
  localparam logic [2:0] Q4 = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == Q0) || (code == Q1) || (code == Q2) || (code == Q3) || (code == Q4);
  endfunction

endpackage

// File: rtl/fsm_golden_step.sv
// Combinational golden next-state function of the 5-state FSM.
// Any code outside the legal set recovers to Q0.
module fsm_golden_step
  import fsm_lockstep_pkg::*;
(
  input  logic [2:0] cur_i,
  input  logic       a_i,
  output logic [2:0] nxt_o
);

  always_comb begin
    nxt_o = Q0;
    case (cur_i)
      Q0:      nxt_o = Q2;
      Q1:      nxt_o = Q3;
      Q2:      nxt_o = a_i ? Q4 : Q1;
      Q3:      nxt_o = a_i ? Q2 : Q0;
      Q4:      nxt_o = Q1;
      default: nxt_o = Q0;
    endcase
  end

endmodule

// File: rtl/fsm_lockstep_ctrl.sv
// Lockstep controller: resets the FSMs under test, feeds them a pattern and checks their voted state.
// Macro LOCKSTEP_VOTE_EN enables 2-of-3 voting and disagree detection; otherwise only s0 is checked.
module fsm_lockstep_ctrl
  import fsm_lockstep_pkg::*;
#(
  parameter  int PAT_W = 16,
  parameter  int CNT_W = 8,
  localparam int LW    = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LW-1:0]    len,
  output logic             fsm_res,
  output logic             a_out,
  input  logic [2:0]       s0,
  input  logic [2:0]       s1,
  input  logic [2:0]       s2,
  output logic [2:0]       voted,
  output logic             busy,
  output logic             done,
  output logic             disagree,
  output logic             mismatch,
  output logic             illegal,
  output logic [LW-1:0]    err_step,
  output logic [CNT_W-1:0] err_count
);

  ctrl_state_e      state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LW-1:0]    len_q, step_q, step_d, step_inc, len_clamp;
  logic [2:0]       exp_q, exp_nxt;
  logic             a_out_q, fsm_res_q, armed_q;
  logic             disagree_q, mismatch_q, illegal_q;
  logic [LW-1:0]    err_step_q;
  logic [CNT_W-1:0] err_count_q;
  logic             chk_en, pair_diff, mis, ill, err, a_bit;
  logic [PAT_W-1:0] pat_sh;

`ifdef LOCKSTEP_VOTE_EN
  assign voted     = (s0 & s1) | (s0 & s2) | (s1 & s2);
  assign pair_diff = (s0 != s1) || (s1 != s2) || (s0 != s2);
`else
  logic s12_unused;
  assign s12_unused = ^{s1, s2};
  assign voted      = s0;
  assign pair_diff  = 1'b0;
`endif

  assign step_inc  = step_q + 1'b1;
  assign len_clamp = (len > LW'(PAT_W)) ? LW'(PAT_W) : len;
  assign mis       = (voted != exp_q);
  assign ill       = !is_legal(voted);
  assign err       = chk_en && (mis || ill);

  // Bit of the pattern for the step about to be entered, registered into a_out.
  assign pat_sh = pat_q >> step_d;
  assign a_bit  = |(pat_sh & {{(PAT_W-1){1'b0}}, 1'b1});

  fsm_golden_step u_gold (
    .cur_i (exp_q),
    .a_i   (a_out_q),
    .nxt_o (exp_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE:  if (start && armed_q) state_d = ST_RST;
      ST_RST: begin
        state_d = (len_q == '0) ? ST_CHECK : ST_RUN;
        step_d  = '0;
      end
      ST_RUN: begin
        step_d = step_inc;
        if (step_inc == len_q) state_d = ST_CHECK;
      end
      ST_CHECK: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_DONE);
    chk_en = (state_q == ST_RUN) || (state_q == ST_CHECK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q       <= '0;
      len_q       <= '0;
      step_q      <= '0;
      exp_q       <= Q0;
      a_out_q     <= 1'b0;
      fsm_res_q   <= 1'b0;
      armed_q     <= 1'b0;
      disagree_q  <= 1'b0;
      mismatch_q  <= 1'b0;
      illegal_q   <= 1'b0;
      err_step_q  <= '0;
      err_count_q <= '0;
    end else begin
      // armed_q blocks a start that arrives on the first edge after reset release.
      armed_q   <= 1'b1;
      fsm_res_q <= (state_d != ST_RST);
      a_out_q   <= (state_d == ST_RUN) ? a_bit : 1'b0;
      step_q    <= step_d;
      case (state_q)
        ST_IDLE: if (state_d == ST_RST) begin
          pat_q       <= pattern;
          len_q       <= len_clamp;
          disagree_q  <= 1'b0;
          mismatch_q  <= 1'b0;
          illegal_q   <= 1'b0;
          err_step_q  <= '0;
          err_count_q <= '0;
        end
        ST_RST: exp_q <= Q0;
        ST_RUN: exp_q <= exp_nxt;
        default: ;
      endcase
      if (chk_en) begin
        if (pair_diff) disagree_q <= 1'b1;
        if (mis)       mismatch_q <= 1'b1;
        if (ill)       illegal_q  <= 1'b1;
        if (err && !mismatch_q && !illegal_q) err_step_q <= step_q;
        if (err && (err_count_q != '1))       err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign fsm_res   = fsm_res_q;
  assign a_out     = a_out_q;
  assign disagree  = disagree_q;
  assign mismatch  = mismatch_q;
  assign illegal   = illegal_q;
  assign err_step  = err_step_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_fsm_lockstep_ctrl.sv
// Bench for fsm_lockstep_ctrl: three behavioural FSM stand-ins with fault injection, table plus corner sequences.
module tb_fsm_lockstep_ctrl;

  localparam int PAT_W = 16;
  localparam int CNT_W = 3;
  localparam int LW    = 5;
`ifdef LOCKSTEP_VOTE_EN
  localparam bit VOTE = 1'b1;
`else
  localparam bit VOTE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [LW-1:0]    len = '0;
  logic             fsm_res, a_out, busy, done, disagree, mismatch, illegal;
  logic [2:0]       s0, s1, s2, voted;
  logic [LW-1:0]    err_step;
  logic [CNT_W-1:0] err_count;

  logic [2:0] st0, st1, st2;
  logic [7:0] tcnt;
  logic [1:0] mode = 2'd0;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fsm_lockstep_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .fsm_res(fsm_res), .a_out(a_out), .s0(s0), .s1(s1), .s2(s2), .voted(voted),
    .busy(busy), .done(done), .disagree(disagree), .mismatch(mismatch),
    .illegal(illegal), .err_step(err_step), .err_count(err_count)
  );

  function automatic logic [2:0] fsm_next(input logic [2:0] c, input logic a);
    case (c)
      3'd2:    return 3'd4;
      3'd6:    return 3'd7;
      3'd4:    return a ? 3'd1 : 3'd6;
      3'd7:    return a ? 3'd4 : 3'd2;
      3'd1:    return 3'd6;
      default: return 3'd2;
    endcase
  endfunction

  always_ff @(posedge clk or negedge fsm_res) begin
    if (!fsm_res) begin
      st0 <= 3'd2; st1 <= 3'd2; st2 <= 3'd2;
    end else begin
      st0 <= fsm_next(st0, a_out);
      st1 <= fsm_next(st1, a_out);
      st2 <= fsm_next(st2, a_out);
    end
  end

  // Step index seen by the FSMs: 0 in the first RUN cycle, len in CHECK.
  always_ff @(posedge clk) tcnt <= fsm_res ? tcnt + 8'd1 : 8'd0;

  always_comb begin
    s0 = st0; s1 = st1; s2 = st2;
    case (mode)
      2'd1: s2 = 3'd6;
      2'd2: if (tcnt >= 8'd3) begin s0 = 3'd4; s1 = 3'd4; end
      2'd3: begin s0 = 3'd0; s1 = 3'd0; s2 = 3'd0; end
      default: ;
    endcase
  end

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  len;
    logic [1:0]  mode;
    bit          mis, ill, dis;
    logic [4:0]  estep;
    logic [2:0]  ecnt;
    int          cyc;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] p, input logic [4:0] l, input logic [1:0] m,
                              input bit mi, input bit il, input bit di,
                              input logic [4:0] es, input logic [2:0] ec, input int cy);
    vec_t v;
    v.pat = p; v.len = l; v.mode = m; v.mis = mi; v.ill = il; v.dis = di;
    v.estep = es; v.ecnt = ec; v.cyc = cy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit poke);
    int          bcnt, cyc, le;
    bit          seen, vbad;
    logic [15:0] abits, mask;
    logic [2:0]  vexp;
    pattern = v.pat; len = v.len; mode = v.mode;
    abits = '0; bcnt = 0; cyc = 0; seen = 0; vbad = 0;
    le   = (v.len > 5'd16) ? 16 : int'(v.len);
    mask = (le == 16) ? 16'hFFFF : ((16'h1 << le) - 16'h1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!seen && cyc < 100) begin
      if (busy) bcnt++;
      if (done) seen = 1;
      if (busy && fsm_res && tcnt < 8'd16) abits[tcnt[3:0]] = a_out;
      vexp = VOTE ? ((s0 & s1) | (s0 & s2) | (s1 & s2)) : s0;
      if (voted !== vexp) vbad = 1;
      if (poke && cyc == 2) begin
        start = 1'b1; pattern = 16'hFFFF; len = 5'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    chk({tag, ".done_seen"},  32'(seen), 32'd1);
    chk({tag, ".busy_cyc"},   32'(bcnt), 32'(v.cyc));
    chk({tag, ".idle_after"}, 32'(busy), 32'd0);
    chk({tag, ".a_bits"},     32'(abits & mask), 32'(v.pat & mask));
    chk({tag, ".voted"},      32'(vbad), 32'd0);
    chk({tag, ".mismatch"},   32'(mismatch), 32'(v.mis));
    chk({tag, ".illegal"},    32'(illegal), 32'(v.ill));
    chk({tag, ".disagree"},   32'(disagree), 32'(v.dis));
    chk({tag, ".err_step"},   32'(err_step), 32'(v.estep));
    chk({tag, ".err_count"},  32'(err_count), 32'(v.ecnt));
  endtask

  vec_t tab[9];

  initial begin
    tab[0] = mk(16'h0000, 5'd5,  2'd0, 0, 0, 0,    5'd0, 3'd0, 8);
    tab[1] = mk(16'h0006, 5'd4,  2'd0, 0, 0, 0,    5'd0, 3'd0, 7);
    tab[2] = mk(16'h0000, 5'd5,  2'd1, 0, 0, VOTE, 5'd0, 3'd0, 8);
    tab[3] = mk(16'h0000, 5'd5,  2'd2, 1, 0, VOTE, 5'd3, 3'd2, 8);
    tab[4] = mk(16'h0000, 5'd5,  2'd3, 1, 1, 0,    5'd0, 3'd6, 8);
    tab[5] = mk(16'hA5C3, 5'd0,  2'd0, 0, 0, 0,    5'd0, 3'd0, 3);
    tab[6] = mk(16'hA5C3, 5'd20, 2'd0, 0, 0, 0,    5'd0, 3'd0, 19);
    tab[7] = mk(16'hFFFF, 5'd16, 2'd0, 0, 0, 0,    5'd0, 3'd0, 19);
    tab[8] = mk(16'h0000, 5'd16, 2'd3, 1, 1, 0,    5'd0, 3'd7, 19);

    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.outputs", 32'({fsm_res, a_out, busy, done, disagree, mismatch, illegal, err_step, err_count}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle.fsm_res", 32'(fsm_res), 32'd1);
    chk("idle.busy",    32'(busy),    32'd0);

    for (int i = 0; i < 9; i++) run_vec(tab[i], $sformatf("vec%0d", i), 1'b0);

    run_vec(mk(16'h0000, 5'd5, 2'd0, 0, 0, 0, 5'd0, 3'd0, 8), "poke", 1'b1);

    // Reset at step 2 of an erroring run with a_out high.
    pattern = 16'hFFFF; len = 5'd5; mode = 2'd3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun.pre_flags", 32'({a_out, mismatch, illegal}), 32'h7);
    reset = 1'b0;
    #1;
    chk("midrun.reset_outputs", 32'({fsm_res, a_out, busy, done, disagree, mismatch, illegal, err_step, err_count}), 32'd0);
    @(negedge clk);
    start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("release.start_ignored", 32'(busy), 32'd0);
    chk("release.fsm_res", 32'(fsm_res), 32'd1);
    mode = 2'd0;
    run_vec(mk(16'h0006, 5'd4, 2'd0, 0, 0, 0, 5'd0, 3'd0, 7), "after_reset", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
